// File: rtl/sound_scheduler.sv
// Tone-path event scheduler: edge-detects game events, queues their frequency codes
// in a small FIFO and plays them one at a time as fixed-length notes followed by a fixed gap.
module sound_scheduler #(
  parameter int DEPTH       = 4,
  parameter int NOTE_CYCLES = 1_200_000,
  parameter int GAP_CYCLES  = 120_000
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     goodColl_i,
  input  logic                     badColl_i,
  input  logic                     button_i,
  input  logic [3:0]               direction_i,
  output logic [8:0]               freq_o,
  output logic                     playSound_o,
  output logic                     busy_o,
  output logic                     dropped_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW     = $clog2(DEPTH);
  localparam int NUM_EV = 7;
  localparam logic [23:0] NOTE_LD = 24'(NOTE_CYCLES - 1);
  localparam logic [23:0] GAP_LD  = 24'(GAP_CYCLES - 1);

  // Lane index is priority order: lane 0 wins, direction lanes follow up/down/left/right.
  localparam logic [NUM_EV-1:0][8:0] CODES = {
    9'd210, 9'd190, 9'd170, 9'd150, 9'd300, 9'd200, 9'd400
  };

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  logic [NUM_EV-1:0]           lvl, prev, rise;
  logic                        ev_vld;
  logic [8:0]                  ev_code;
  logic [DEPTH-1:0][8:0]       mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [AW:0]                 count, count_nxt;
  logic                        full, pop, push, drop, busy_nxt;
  state_t                      state;
  logic [23:0]                 cnt;

  assign lvl  = {direction_i[3], direction_i[2], direction_i[1], direction_i[0],
                 button_i, goodColl_i, badColl_i};
  assign rise = lvl & ~prev;

  always_comb begin
    ev_vld  = 1'b0;
    ev_code = '0;
    for (int i = NUM_EV - 1; i >= 0; i--) begin
      if (rise[i]) begin
        ev_vld  = 1'b1;
        ev_code = CODES[i];
      end
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts alongside a pop.
  assign full = (count == (AW+1)'(DEPTH));
  assign pop  = (state == IDLE) && (count != '0);
  assign push = ev_vld && (!full || pop);
  assign drop = ev_vld && full && !pop;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  assign busy_nxt = ((state == IDLE) ? pop : !((state == GAP) && (cnt == '0)))
                    || (count_nxt != '0);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      prev      <= '0;
      mem       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dropped_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      prev      <= lvl;
      dropped_o <= drop;
      busy_o    <= busy_nxt;
      count     <= count_nxt;
      if (push) begin
        mem[wr_ptr] <= ev_code;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign count_o = count;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= IDLE;
      cnt         <= '0;
      freq_o      <= '0;
      playSound_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          freq_o      <= mem[rd_ptr];
          cnt         <= NOTE_LD;
          playSound_o <= 1'b1;
          state       <= PLAY;
        end
        PLAY: if (cnt == '0) begin
          cnt         <= GAP_LD;
          playSound_o <= 1'b0;
          state       <= GAP;
        end else begin
          cnt <= cnt - 1'b1;
        end
        GAP: if (cnt == '0) state <= IDLE;
             else           cnt   <= cnt - 1'b1;
        default: begin
          state       <= IDLE;
          playSound_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: random and directed stimulus against a queue-based
// reference model that tracks note timing by cycle arithmetic from each pop.
module tb_sound_scheduler;
  localparam int N = 4;
  localparam int G = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       good = 1'b0, bad = 1'b0, btn = 1'b0;
  logic [3:0] dir = '0;
  logic [8:0] freq;
  logic       play, busy, dropped;
  logic [2:0] count;

  always #5 clk = ~clk;

  sound_scheduler #(.DEPTH(D), .NOTE_CYCLES(N), .GAP_CYCLES(G)) dut (
    .clk(clk), .nRst(nRst), .goodColl_i(good), .badColl_i(bad), .button_i(btn),
    .direction_i(dir), .freq_o(freq), .playSound_o(play), .busy_o(busy),
    .dropped_o(dropped), .count_o(count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: lane 0 = badColl, 1 = goodColl, 2 = button, 3..6 = up/down/left/right.
  int         codes[7] = '{400, 200, 300, 150, 170, 190, 210};
  int         q[$];
  int         k = 0;
  int         start_k = -1;
  int         m_freq = 0;
  bit         m_drop = 1'b0;
  logic [6:0] m_prev = '0;

  // Observation log of note starts
  int         rise_f[$];
  int         rise_k[$];
  logic       play_d = 1'b0;
  int         drop_seen = 0;
  int         max_count = 0;

  task automatic model_reset();
    q.delete();
    start_k = -1;
    m_freq  = 0;
    m_drop  = 1'b0;
    m_prev  = '0;
    play_d  = 1'b0;
  endtask

  task automatic model_edge(input logic [6:0] lv);
    bit idle, do_pop;
    int pre, sel;
    k++;
    idle   = (start_k < 0) || (k >= start_k + N + G + 1);
    pre    = q.size();
    do_pop = idle && (pre > 0);
    sel    = -1;
    for (int i = 0; i < 7; i++)
      if (lv[i] && !m_prev[i] && sel < 0) sel = i;
    m_drop = 1'b0;
    if (do_pop) begin
      m_freq  = q.pop_front();
      start_k = k;
    end
    if (sel >= 0) begin
      if (pre < D || do_pop) q.push_back(codes[sel]);
      else                   m_drop = 1'b1;
    end
    m_prev = lv;
  endtask

  task automatic check_outputs();
    bit e_play, e_idle;
    e_play = (start_k >= 0) && (k - start_k < N);
    e_idle = (start_k < 0) || (k >= start_k + N + G);
    chk("freq", freq, m_freq);
    chk("play", play, e_play);
    chk("busy", busy, (!e_idle) || (q.size() > 0));
    chk("dropped", dropped, m_drop);
    chk("count", count, q.size());
    if (play && !play_d) begin
      rise_f.push_back(int'(freq));
      rise_k.push_back(k);
    end
    play_d = play;
    if (dropped) drop_seen++;
    if (int'(count) > max_count) max_count = int'(count);
  endtask

  task automatic step(input logic [6:0] lv);
    {dir, btn, good, bad} = lv;
    @(posedge clk);
    model_edge(lv);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(7'd0);
  endtask

  initial begin
    int n0;
    logic [6:0] seq5[5];
    int exp5[5];
    seq5 = '{7'b0000100, 7'b0001000, 7'b0010000, 7'b0100000, 7'b1000000};
    exp5 = '{300, 150, 170, 190, 210};

    // Reset held with inputs toggling
    nRst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      {dir, btn, good, bad} = 7'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("rst_out", {freq, play, busy, dropped, count}, 0);
    end
    {dir, btn, good, bad} = '0;
    nRst = 1'b1;
    model_reset();
    idle_steps(6);

    // Single goodColl pulse
    n0 = rise_f.size();
    step(7'b0000010);
    chk("good_cnt", count, 1);
    idle_steps(12);
    chk("good_notes", rise_f.size() - n0, 1);
    if (rise_f.size() > n0) chk("good_freq", rise_f[n0], 200);

    // badColl together with direction 0110
    n0 = rise_f.size();
    max_count = 0;
    step(7'b0110001);
    idle_steps(14);
    chk("simul_notes", rise_f.size() - n0, 1);
    if (rise_f.size() > n0) chk("simul_freq", rise_f[n0], 400);
    chk("simul_maxcnt", max_count, 1);

    // Five events two cycles apart
    n0 = rise_f.size();
    drop_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(seq5[i]);
      step(7'd0);
    end
    idle_steps(40);
    chk("seq_drops", drop_seen, 0);
    chk("seq_notes", rise_f.size() - n0, 5);
    if (rise_f.size() - n0 == 5)
      for (int i = 0; i < 5; i++) begin
        chk("seq_freq", rise_f[n0+i], exp5[i]);
        if (i > 0) chk("seq_space", rise_k[n0+i] - rise_k[n0+i-1], N + G + 1);
      end

    // Overflow: a new edge every cycle on rotating lanes
    drop_seen = 0;
    max_count = 0;
    for (int i = 0; i < 11; i++) step(7'(1 << (i % 7)));
    idle_steps(50);
    chk("ovf_drops", drop_seen, 5);
    chk("ovf_maxcnt", max_count, 4);

    // Random traffic with sparse edges
    for (int i = 0; i < 400; i++)
      step(7'($urandom & $urandom & $urandom));
    idle_steps(50);

    // Reset in the middle of a note with three events queued
    step(7'b0000001);
    step(7'b0000010);
    step(7'b0000100);
    step(7'b0001000);
    {dir, btn, good, bad} = '0;
    chk("pre_rst_play", play, 1);
    chk("pre_rst_cnt", count, 3);
    #2 nRst = 1'b0;
    #1;
    chk("async_play", play, 0);
    chk("async_cnt", count, 0);
    chk("async_busy", busy, 0);
    chk("async_freq", freq, 0);
    @(negedge clk);
    nRst = 1'b1;
    model_reset();
    n0 = rise_f.size();
    idle_steps(15);
    chk("post_rst_notes", rise_f.size() - n0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sound_scheduler.md
# sound_scheduler

Event scheduler for the tone path. It captures game sound events (good/bad collision, button, direction), queues them in a small FIFO, and plays them one at a time on the shared oscillator. For each event it drives a fixed-length note with the event's frequency code, followed by a fixed silent gap. It sits between the game-logic event sources and the oscillator/DAC chain, and replaces direct per-event triggering so that back-to-back events are no longer lost or truncated.

## Interface
- `DEPTH`, default 4: FIFO entries; power of 2, range 2..16.
- `NOTE_CYCLES`, default 1_200_000: cycles `playSound_o` stays high per note (100 ms at 12 MHz); range 1..2^24-1.
- `GAP_CYCLES`, default 120_000: silent cycles after each note; range 1..2^24-1.
- `clk`  in  1: system clock (12 MHz).
- `nRst`  in  1: reset; one clock; reset is asynchronous and active-low.
- `goodColl_i`  in  1: good-collision level, synchronous to `clk`.
- `badColl_i`  in  1: bad-collision level.
- `button_i`  in  1: button level.
- `direction_i`  in  4: direction levels; bit 0 up, 1 down, 2 left, 3 right.
- `freq_o`  out  9: frequency code to the oscillator, valid while `playSound_o` is high.
- `playSound_o`  out  1: oscillator enable.
- `busy_o`  out  1: high when the FSM is not IDLE or the FIFO is non-empty.
- `dropped_o`  out  1: one-cycle pulse when an event is discarded because the FIFO is full.
- `count_o`  out  $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Rising-edge detect on each of the 7 input bits. Previous-value registers reset to 0, so an input already high when reset releases produces one event.
- Only one enqueue is allowed per cycle. When several edges occur in the same cycle, the highest-priority one is kept: badColl > goodColl > button > direction. Among direction bits, the lowest index wins. All other simultaneous edges are discarded silently (no `dropped_o`).
- Each event is stored as its 9-bit frequency code:
  - badColl = 400
  - goodColl = 200
  - button = 300
  - up = 150, down = 170, left = 190, right = 210
- FIFO full at the time of an enqueue: the event is discarded and `dropped_o` is high for the next cycle. Queue contents are unchanged.
- FIFO read/write pointers wrap modulo DEPTH. Enqueue and pop in the same cycle are both allowed; occupancy is then unchanged, including when the FIFO is full.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head, load it into the `freq_o` register, load the counter with NOTE_CYCLES-1, and go to PLAY.
  - PLAY: `playSound_o` = 1. Decrement the counter. At 0, load GAP_CYCLES-1 and go to GAP.
  - GAP: `playSound_o` = 0. Decrement the counter. At 0, go to IDLE.
- Notes are never pre-empted; a badColl queued during a note waits its turn.
- `freq_o` holds the last note's code through GAP and IDLE. It changes only on a pop.
- Counter is 24 bits, unsigned, decrement only. It never underflows because the terminal test is `==0`.

## Timing
- Reset values: `freq_o` = 0, `playSound_o` = 0, `busy_o` = 0, `dropped_o` = 0, `count_o` = 0. FSM is IDLE, FIFO is empty, edge registers are 0.
- Reset mid-note or mid-gap: all outputs go to their reset values immediately (asynchronous), and queued events are flushed.
- Latency, with an input sampled low at edge t-1 and high at edge t:
  - enqueued at edge t, so `count_o` increments after t;
  - popped at edge t+1, so `playSound_o` = 1 and `freq_o` is valid after t+1.
- Note length is exactly NOTE_CYCLES cycles of `playSound_o` = 1. The gap is exactly GAP_CYCLES cycles.
- Back-to-back notes: next `playSound_o` rise = previous rise + NOTE_CYCLES + GAP_CYCLES + 1 (one IDLE cycle).
- `busy_o` is registered from next-state values, so it asserts together with `count_o`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use NOTE_CYCLES=4, GAP_CYCLES=2, DEPTH=4.
- Reset behaviour: hold `nRst` = 0 with all inputs toggling; release with all inputs 0 -> every output is 0 and stays 0.
- Single goodColl pulse at edge 10 -> `count_o` = 1 after edge 10; `playSound_o` is high for edges 11..14 with `freq_o` = 200; low during the 2 gap cycles; `busy_o` = 0 after edge 17.
- Simultaneous `badColl_i` and `direction_i` = 4'b0110 rising at the same edge -> exactly one note, `freq_o` = 400, `count_o` never exceeds 1.
- Five single-cycle events 2 cycles apart (button, up, down, left, right), starting while idle -> first event pops immediately, the remaining 4 fill the FIFO. Observe on a bench sweep:
  - whether a `dropped_o` pulse appears;
  - the played sequence is 300, 150, 170, 190, 210 when all fit, with spacing of 7 cycles between note starts.
- Overflow: with a note playing, 5 edges arrive while the FIFO already holds 4 -> `dropped_o` pulses once per excess edge, and `count_o` holds at 4.
- Reset mid-note: assert `nRst` = 0 during PLAY with 3 events queued -> `playSound_o` = 0 asynchronously; after release `count_o` = 0 and no note plays.
